// File: rtl/sqrt_iter_hs_if.sv
// Operand/result handshake bundle for sqrt_iter_hs.
// master drives operands and result-ready; slave is the square-root unit.
interface sqrt_iter_hs_if #(
  parameter int MW = 10,
  parameter int EW = 7
);
  logic          in_valid;
  logic          in_ready;
  logic          in_sign;
  logic [EW-1:0] in_exp;
  logic [MW-1:0] in_mant;
  logic          in_is_nan;
  logic          in_is_pinf;
  logic          in_is_ninf;

  logic          out_valid;
  logic          out_ready;
  logic          out_sign;
  logic [EW-1:0] out_exp;
  logic [MW-1:0] out_mant;
  logic          out_is_nan;
  logic          out_is_pinf;
  logic          out_is_ninf;

  modport master (
    output in_valid, in_sign, in_exp, in_mant,
    output in_is_nan, in_is_pinf, in_is_ninf,
    output out_ready,
    input  in_ready,
    input  out_valid, out_sign, out_exp, out_mant,
    input  out_is_nan, out_is_pinf, out_is_ninf
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant,
    input  in_is_nan, in_is_pinf, in_is_ninf,
    input  out_ready,
    output in_ready,
    output out_valid, out_sign, out_exp, out_mant,
    output out_is_nan, out_is_pinf, out_is_ninf
  );
endinterface

// File: rtl/sqrt_iter_hs.sv
// Iterative radix-2 restoring square root (one root bit per cycle) with valid/ready on both sides.
// Optional round-to-nearest-even is enabled by defining SQRT_ROUND_EN; otherwise results truncate.
module sqrt_iter_hs #(
  parameter int MW       = 10,
  parameter int EW       = 7,
  parameter int EXP_ZERO = -15,
  parameter int EXP_SPEC = 16
) (
  input  logic          clk,
  input  logic          rst,
  sqrt_iter_hs_if.slave io,
  output logic          busy
);

  localparam int RW  = MW + 2;
  localparam int RMW = MW + 4;
  localparam int DW  = 2 * RW;
  localparam int CW  = $clog2(RW + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [EW-1:0] EXP_ZERO_C = EW'(EXP_ZERO);
  localparam logic [EW-1:0] EXP_SPEC_C = EW'(EXP_SPEC);
  localparam logic [CW-1:0] CNT_INIT   = CW'(RW);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [MW-1:0] MANT_ZERO  = {MW{1'b0}};
  localparam logic [MW-1:0] NAN_MANT   = {1'b1, {(MW-1){1'b0}}};

`ifdef SQRT_ROUND_EN
  // Returns {carry, fraction}; carry flags the all-ones fraction wrapping to zero.
  function automatic logic [MW:0] round_rne(input logic [MW-1:0] frac,
                                            input logic          guard,
                                            input logic          sticky);
    logic up;
    up = guard & (sticky | frac[0]);
    return {up & (&frac), frac + MW'(up)};
  endfunction
`endif

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  rad_q, rad_d;
  logic [RMW-1:0] rem_q, rem_d;
  logic [RW-1:0]  root_q, root_d;
  logic [EW-1:0]  exp_q, exp_d;

  logic           out_valid_q, out_valid_d;
  logic           out_sign_q, out_sign_d;
  logic [EW-1:0]  out_exp_q, out_exp_d;
  logic [MW-1:0]  out_mant_q, out_mant_d;
  logic           out_nan_q, out_nan_d;
  logic           out_pinf_q, out_pinf_d;

  logic           in_ready_s;
  logic           accept_s;
  logic           is_zero_s;
  logic           is_nan_s;
  logic           is_special_s;
  logic [EW-1:0]  exp_half_s;
  logic [RW-1:0]  sig_s;

  logic [RMW+1:0] trial_s;
  logic [RMW+1:0] sub_s;
  logic           ge_s;
  logic [RMW-1:0] rem_nxt_s;
  logic [RW-1:0]  root_nxt_s;
  logic [MW-1:0]  frac_s;
  logic [MW-1:0]  res_mant_s;
  logic [EW-1:0]  res_exp_s;

  assign in_ready_s = (state_q == IDLE) && !rst;
  assign accept_s   = io.in_valid && in_ready_s;

  // Operand classification: negative non-zero operands have no real root.
  assign is_zero_s    = (io.in_exp == EXP_ZERO_C) && (io.in_mant == MANT_ZERO);
  assign is_nan_s     = io.in_is_nan | io.in_is_ninf | (io.in_sign & ~is_zero_s);
  assign is_special_s = is_nan_s | io.in_is_pinf | is_zero_s;

  // Odd exponents fold one factor of two into the significand so the halved exponent is exact.
  assign exp_half_s = $signed(io.in_exp) >>> 1;
  assign sig_s      = io.in_exp[0] ? {1'b1, io.in_mant, 1'b0} : {2'b01, io.in_mant};

  // One restoring step: bring down two radicand bits, try subtracting {root, 01}.
  assign trial_s    = {rem_q, rad_q[DW-1 -: 2]};
  assign sub_s      = {2'b00, root_q, 2'b01};
  assign ge_s       = (trial_s >= sub_s);
  assign rem_nxt_s  = ge_s ? (trial_s[RMW-1:0] - sub_s[RMW-1:0]) : trial_s[RMW-1:0];
  assign root_nxt_s = {root_q[RW-2:0], ge_s};
  assign frac_s     = root_nxt_s[MW:1];

`ifdef SQRT_ROUND_EN
  logic [MW:0] rounded_s;
  assign rounded_s  = round_rne(frac_s, root_nxt_s[0], |rem_nxt_s);
  assign res_mant_s = rounded_s[MW-1:0];
  assign res_exp_s  = exp_q + EW'(rounded_s[MW]);
`else
  assign res_mant_s = frac_s;
  assign res_exp_s  = exp_q;
`endif

  // Next-state and result-capture logic for the IDLE/CALC/DONE controller.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rad_d       = rad_q;
    rem_d       = rem_q;
    root_d      = root_q;
    exp_d       = exp_q;
    out_valid_d = out_valid_q;
    out_sign_d  = out_sign_q;
    out_exp_d   = out_exp_q;
    out_mant_d  = out_mant_q;
    out_nan_d   = out_nan_q;
    out_pinf_d  = out_pinf_q;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (is_special_s) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            if (is_nan_s) begin
              out_sign_d = 1'b1;
              out_exp_d  = EXP_SPEC_C;
              out_mant_d = NAN_MANT;
              out_nan_d  = 1'b1;
              out_pinf_d = 1'b0;
            end else if (io.in_is_pinf) begin
              out_sign_d = 1'b0;
              out_exp_d  = EXP_SPEC_C;
              out_mant_d = MANT_ZERO;
              out_nan_d  = 1'b0;
              out_pinf_d = 1'b1;
            end else begin
              out_sign_d = io.in_sign;
              out_exp_d  = EXP_ZERO_C;
              out_mant_d = MANT_ZERO;
              out_nan_d  = 1'b0;
              out_pinf_d = 1'b0;
            end
          end else begin
            state_d = CALC;
            cnt_d   = CNT_INIT;
            rad_d   = {sig_s, {RW{1'b0}}};
            rem_d   = {RMW{1'b0}};
            root_d  = {RW{1'b0}};
            exp_d   = exp_half_s;
          end
        end else begin
          state_d = IDLE;
        end
      end

      CALC: begin
        rad_d  = {rad_q[DW-3:0], 2'b00};
        rem_d  = rem_nxt_s;
        root_d = root_nxt_s;
        if (cnt_q == CNT_ONE) begin
          state_d     = DONE;
          cnt_d       = {CW{1'b0}};
          out_valid_d = 1'b1;
          out_sign_d  = 1'b0;
          out_exp_d   = res_exp_s;
          out_mant_d  = res_mant_s;
          out_nan_d   = 1'b0;
          out_pinf_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      DONE: begin
        if (io.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      rad_q       <= {DW{1'b0}};
      rem_q       <= {RMW{1'b0}};
      root_q      <= {RW{1'b0}};
      exp_q       <= {EW{1'b0}};
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= {EW{1'b0}};
      out_mant_q  <= MANT_ZERO;
      out_nan_q   <= 1'b0;
      out_pinf_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rad_q       <= rad_d;
      rem_q       <= rem_d;
      root_q      <= root_d;
      exp_q       <= exp_d;
      out_valid_q <= out_valid_d;
      out_sign_q  <= out_sign_d;
      out_exp_q   <= out_exp_d;
      out_mant_q  <= out_mant_d;
      out_nan_q   <= out_nan_d;
      out_pinf_q  <= out_pinf_d;
    end
  end

  assign io.in_ready    = in_ready_s;
  assign io.out_valid   = out_valid_q;
  assign io.out_sign    = out_sign_q;
  assign io.out_exp     = out_exp_q;
  assign io.out_mant    = out_mant_q;
  assign io.out_is_nan  = out_nan_q;
  assign io.out_is_pinf = out_pinf_q;
  assign io.out_is_ninf = 1'b0;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_sqrt_iter_hs.sv
// Directed bench for sqrt_iter_hs: scoreboard of expected results, immediate-assert checks.
module tb_sqrt_iter_hs;
  localparam int MW = 10;
  localparam int EW = 7;

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] ex;
    logic [MW-1:0] mant;
    logic          nan;
    logic          pinf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  sqrt_iter_hs_if #(.MW(MW), .EW(EW)) io ();

  sqrt_iter_hs #(.MW(MW), .EW(EW), .EXP_ZERO(-15), .EXP_SPEC(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .io   (io),
    .busy (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic s, input logic [EW-1:0] e, input logic [MW-1:0] m,
                              input logic nan, input logic pinf);
    exp_t r;
    r.sign = s; r.ex = e; r.mant = m; r.nan = nan; r.pinf = pinf;
    return r;
  endfunction

  // Reference: bitwise integer square root by squaring trial roots.
  function automatic exp_t model(input logic [EW-1:0] e, input logic [MW-1:0] m);
    logic [11:0]   s;
    logic [23:0]   rad;
    logic [11:0]   r;
    logic [11:0]   t;
    logic [MW-1:0] frac;
    logic [EW-1:0] ex;
    s   = e[0] ? {1'b1, m, 1'b0} : {2'b01, m};
    rad = {s, 12'h000};
    r   = 12'h000;
    for (int b = 11; b >= 0; b--) begin
      t = r | (12'h001 << b);
      if (longint'(t) * longint'(t) <= longint'(rad)) r = t;
    end
    frac = r[10:1];
    ex   = EW'($signed(e) >>> 1);
`ifdef SQRT_ROUND_EN
    if (r[0] && ((longint'(r) * longint'(r) != longint'(rad)) || frac[0])) begin
      if (&frac) ex = ex + 7'd1;
      frac = frac + 10'd1;
    end
`endif
    return mk(1'b0, ex, frac, 1'b0, 1'b0);
  endfunction

  task automatic drive(input logic s, input logic [EW-1:0] e, input logic [MW-1:0] m,
                       input logic nan, input logic pinf, input logic ninf);
    io.in_sign = s; io.in_exp = e; io.in_mant = m;
    io.in_is_nan = nan; io.in_is_pinf = pinf; io.in_is_ninf = ninf;
  endtask

  task automatic send(input string tag, input logic s, input logic [EW-1:0] e,
                      input logic [MW-1:0] m, input logic nan, input logic pinf,
                      input logic ninf, input exp_t expv, input bit push);
    @(negedge clk);
    drive(s, e, m, nan, pinf, ninf);
    io.in_valid = 1'b1;
    chk({tag, "_in_ready"}, 32'(io.in_ready), 32'd1);
    if (push) sb.push_back(expv);
    @(posedge clk);
    #1 io.in_valid = 1'b0;
  endtask

  // Waits for out_valid, checks latency and fields; noise pulses in_valid while busy.
  task automatic collect(input string tag, input int exp_lat, input int hold);
    int   lat;
    exp_t e;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (hold > 0 && !io.out_valid) begin
        drive(1'b0, 7'h02, 10'h000, 1'b0, 1'b1, 1'b0);
        io.in_valid = 1'b1;
        chk({tag, "_calc_in_ready"}, 32'(io.in_ready), 32'd0);
      end
    end while (!io.out_valid && lat < 40);
    chk({tag, "_out_valid"}, 32'(io.out_valid), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    if (sb.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    chk({tag, "_sign"}, 32'(io.out_sign), 32'(e.sign));
    chk({tag, "_exp"},  32'(io.out_exp),  32'(e.ex));
    chk({tag, "_mant"}, 32'(io.out_mant), 32'(e.mant));
    chk({tag, "_nan"},  32'(io.out_is_nan),  32'(e.nan));
    chk({tag, "_pinf"}, 32'(io.out_is_pinf), 32'(e.pinf));
    chk({tag, "_ninf"}, 32'(io.out_is_ninf), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      io.in_valid = 1'b1;
      chk({tag, "_hold_valid"}, 32'(io.out_valid), 32'd1);
      chk({tag, "_hold_exp"},   32'(io.out_exp),   32'(e.ex));
      chk({tag, "_hold_mant"},  32'(io.out_mant),  32'(e.mant));
      chk({tag, "_hold_in_ready"}, 32'(io.in_ready), 32'd0);
    end
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    @(posedge clk);
    #1 io.out_ready = 1'b0;
  endtask

  initial begin
    exp_t e;
    logic [EW-1:0] re;
    logic [MW-1:0] rm;

    rst = 1'b1;
    io.in_valid = 1'b0;
    io.out_ready = 1'b0;
    drive(1'b0, 7'h00, 10'h000, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  32'(io.in_ready),  32'd0);
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_busy",      32'(busy),         32'd0);
    chk("rst_out_mant",  32'(io.out_mant),  32'd0);
    chk("rst_out_exp",   32'(io.out_exp),   32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(io.in_ready), 32'd1);

    send("four", 1'b0, 7'h02, 10'h000, 1'b0, 1'b0, 1'b0, mk(1'b0, 7'h01, 10'h000, 1'b0, 1'b0), 1'b1);
    collect("four", 13, 0);
    send("two", 1'b0, 7'h01, 10'h000, 1'b0, 1'b0, 1'b0, mk(1'b0, 7'h00, 10'h1A8, 1'b0, 1'b0), 1'b1);
    collect("two", 13, 0);
`ifdef SQRT_ROUND_EN
    e = mk(1'b0, 7'h00, 10'h2EE, 1'b0, 1'b0);
`else
    e = mk(1'b0, 7'h00, 10'h2ED, 1'b0, 1'b0);
`endif
    send("three", 1'b0, 7'h01, 10'h200, 1'b0, 1'b0, 1'b0, e, 1'b1);
    collect("three", 13, 0);

    send("neg4", 1'b1, 7'h02, 10'h000, 1'b0, 1'b0, 1'b0, mk(1'b1, 7'h10, 10'h200, 1'b1, 1'b0), 1'b1);
    collect("neg4", 1, 0);
    send("pinf", 1'b0, 7'h10, 10'h000, 1'b0, 1'b1, 1'b0, mk(1'b0, 7'h10, 10'h000, 1'b0, 1'b1), 1'b1);
    collect("pinf", 1, 0);
    send("negzero", 1'b1, 7'h71, 10'h000, 1'b0, 1'b0, 1'b0, mk(1'b1, 7'h71, 10'h000, 1'b0, 1'b0), 1'b1);
    collect("negzero", 1, 0);
    send("poszero", 1'b0, 7'h71, 10'h000, 1'b0, 1'b0, 1'b0, mk(1'b0, 7'h71, 10'h000, 1'b0, 1'b0), 1'b1);
    collect("poszero", 1, 0);
    send("ninf", 1'b1, 7'h10, 10'h000, 1'b0, 1'b0, 1'b1, mk(1'b1, 7'h10, 10'h200, 1'b1, 1'b0), 1'b1);
    collect("ninf", 1, 0);
    send("nan_pinf", 1'b0, 7'h10, 10'h000, 1'b1, 1'b1, 1'b0, mk(1'b1, 7'h10, 10'h200, 1'b1, 1'b0), 1'b1);
    collect("nan_pinf", 1, 0);

    // Back-pressure with ignored operands, then an immediate follow-on accept.
    send("bp_two", 1'b0, 7'h01, 10'h000, 1'b0, 1'b0, 1'b0, mk(1'b0, 7'h00, 10'h1A8, 1'b0, 1'b0), 1'b1);
    collect("bp_two", 13, 5);
    send("bp_next", 1'b0, 7'h02, 10'h000, 1'b0, 1'b0, 1'b0, mk(1'b0, 7'h01, 10'h000, 1'b0, 1'b0), 1'b1);
    collect("bp_next", 13, 0);

    for (int i = 0; i < 6; i++) begin
      re = EW'($urandom_range(29, 0) - 14);
      rm = MW'($urandom);
      send("rand", 1'b0, re, rm, 1'b0, 1'b0, 1'b0, model(re, rm), 1'b1);
      collect("rand", 13, 0);
    end

    // Abort mid-calculation: no result may appear.
    send("abort", 1'b0, 7'h03, 10'h155, 1'b0, 1'b0, 1'b0, mk(1'b0, 7'h00, 10'h000, 1'b0, 1'b0), 1'b0);
    repeat (6) @(negedge clk);
    chk("abort_busy_calc", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", 32'(io.out_valid), 32'd0);
    chk("abort_busy",      32'(busy),         32'd0);
    chk("abort_in_ready",  32'(io.in_ready),  32'd1);
    send("quarter", 1'b0, 7'h7E, 10'h000, 1'b0, 1'b0, 1'b0, mk(1'b0, 7'h7F, 10'h000, 1'b0, 1'b0), 1'b1);
    collect("quarter", 13, 0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
